// File: rtl/note_scroll_scan_pkg.sv
// Shared types and default sizing for the note scroll/scan slice.
// Consumed by row_scanner and note_scroll_scan.
package note_scan_pkg;

    localparam int unsigned ROWS_DEF      = 8;
    localparam int unsigned LANES_DEF     = 10;
    localparam int unsigned SCAN_DIV_DEF  = 1000;
    localparam int unsigned BLANK_CYC_DEF = 16;
    localparam int unsigned FLUSH_DIV_DEF = 100000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    // One frame-buffer row: {red lanes, blue lanes}
    typedef logic [2*LANES_DEF-1:0] row_word_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/note_scroll_scan_row_scanner.sv
// Row-period divider, row index and one-hot-low row strobe for the LED matrix.
// Build option SCAN_BLANK_EN: blank the first BLANK_CYC cycles of each row period.
module row_scanner
    import note_scan_pkg::*;
#(
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
    parameter int unsigned BLANK_CYC = BLANK_CYC_DEF,
    localparam int unsigned RW       = cnt_width(ROWS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [ROWS-1:0] row_n,
    output logic [RW-1:0]   row_sel,
    output logic            blank_next
);

    localparam int unsigned DW           = cnt_width(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_LIM  = DW'(BLANK_CYC);
    localparam logic [RW-1:0] IDX_LAST   = RW'(ROWS - 1);
`ifdef SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic [DW-1:0] div_cnt, div_next;
    logic [RW-1:0] row_idx, idx_next;

    always_comb begin
        div_next = div_cnt + 1'b1;
        idx_next = row_idx;
        if (div_cnt == DIV_LAST) begin
            div_next = '0;
            idx_next = (row_idx == IDX_LAST) ? '0 : row_idx + 1'b1;
        end
    end

    assign blank_next = BLANK_EN && (div_next < BLANK_LIM);
    assign row_sel    = idx_next;

    // Strobe is registered from the next-state index so it lines up with the column registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            row_idx <= '0;
            row_n   <= '1;
        end else begin
            div_cnt <= div_next;
            row_idx <= idx_next;
            row_n   <= blank_next ? '1 : ~(ROWS'(1) << idx_next);
        end
    end

endmodule

// File: rtl/note_scroll_scan.sv
// Scrolling bicolour note frame buffer with end-of-song flush, driving a row-scanned LED matrix.
// Build option SCAN_BLANK_EN (in row_scanner): anti-ghost blanking at the start of each row period.
module note_scroll_scan
    import note_scan_pkg::*;
#(
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
    parameter int unsigned BLANK_CYC = BLANK_CYC_DEF,
    parameter int unsigned FLUSH_DIV = FLUSH_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] note_R,
    input  logic [LANES-1:0] note_B,
    input  logic [3:0]       offset,
    input  logic             finish,
    output logic [ROWS-1:0]  row_n,
    output logic [LANES-1:0] col_R,
    output logic [LANES-1:0] col_B,
    output logic             busy,
    output logic             flush_done
);

    localparam int unsigned FW            = cnt_width(FLUSH_DIV);
    localparam int unsigned RW            = cnt_width(ROWS);
    localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_DIV - 1);
    localparam logic [RW-1:0] INS_LAST    = RW'(ROWS - 1);

    state_t state, state_next;

    logic [3:0]         offset_q;
    logic               step;
    logic [2*LANES-1:0] frame [ROWS];
    logic [FW-1:0]      flush_cnt;
    logic [RW-1:0]      ins_cnt;
    logic               flush_tick, flush_last;
    logic               shift_en, shift_zero, done_next;
    logic [RW-1:0]      row_sel;
    logic               blank_next;

    row_scanner #(
        .ROWS      (ROWS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .row_sel    (row_sel),
        .blank_next (blank_next)
    );

    assign step       = (offset != offset_q);
    assign flush_tick = (flush_cnt == FLUSH_LAST);
    assign flush_last = flush_tick && (ins_cnt == INS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (step)       state_next = RUN;
            RUN:     if (finish)     state_next = FLUSH;
            FLUSH:   if (flush_last) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        shift_en   = 1'b0;
        shift_zero = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE, RUN: shift_en = step;
            FLUSH: begin
                shift_en   = flush_tick;
                shift_zero = 1'b1;
                done_next  = flush_last;
            end
            default: ;
        endcase
    end

    // Flush counters sit at zero outside FLUSH, so entering FLUSH starts a clean count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q   <= '0;
            busy       <= 1'b0;
            flush_done <= 1'b0;
            flush_cnt  <= '0;
            ins_cnt    <= '0;
        end else begin
            offset_q   <= offset;
            busy       <= (state_next != IDLE);
            flush_done <= done_next;
            if (state != FLUSH) begin
                flush_cnt <= '0;
                ins_cnt   <= '0;
            end else if (flush_tick) begin
                flush_cnt <= '0;
                ins_cnt   <= ins_cnt + 1'b1;
            end else begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < ROWS; k++) frame[k] <= '0;
            col_R <= '0;
            col_B <= '0;
        end else begin
            if (shift_en) begin
                frame[0] <= shift_zero ? '0 : {note_R, note_B};
                for (int unsigned k = 1; k < ROWS; k++) frame[k] <= frame[k-1];
            end
            col_R <= blank_next ? '0 : frame[row_sel][2*LANES-1:LANES];
            col_B <= blank_next ? '0 : frame[row_sel][LANES-1:0];
        end
    end

endmodule
